// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter sharing one external ALU; ARB_FIXED_PRIO_EN selects fixed priority to requester 0
module alu_share_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req0_valid_in,
  input  logic [1:0]        req0_op_in,
  input  logic [DATA_W-1:0] req0_a_in,
  input  logic [DATA_W-1:0] req0_b_in,
  output logic              req0_ready_out,
  input  logic              req1_valid_in,
  input  logic [1:0]        req1_op_in,
  input  logic [DATA_W-1:0] req1_a_in,
  input  logic [DATA_W-1:0] req1_b_in,
  output logic              req1_ready_out,
  output logic              rsp0_valid_out,
  input  logic              rsp0_ready_in,
  output logic              rsp1_valid_out,
  input  logic              rsp1_ready_in,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic [DATA_W-1:0] alu_a_out,
  output logic [DATA_W-1:0] alu_b_out,
  output logic              alu_s0_out,
  output logic              alu_s1_out,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              busy_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic              winner;
  logic              accept;
  logic              rsp_done;

  // Pick which requester would win if the arbiter were idle this cycle
  always_comb begin
    winner = 1'b0;
    if (req0_valid_in && req1_valid_in) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant_q;
`endif
    end else if (req1_valid_in) begin
      winner = 1'b1;
    end
  end

  // Ready only to the winner, only while idle; forced low while reset is held
  always_comb begin
    req0_ready_out = rst_n_in && (state_q == IDLE) && req0_valid_in && !winner;
    req1_ready_out = rst_n_in && (state_q == IDLE) && req1_valid_in && winner;
    accept         = req0_ready_out || req1_ready_out;
    rsp_done       = grant_q ? rsp1_ready_in : rsp0_ready_in;
  end

  // Next-state logic: accept in IDLE, capture ALU result in EXEC, hold response in RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_op_d     = winner ? req1_op_in : req0_op_in;
          alu_a_d      = winner ? req1_a_in  : req0_a_in;
          alu_b_d      = winner ? req1_b_in  : req0_b_in;
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d   = alu_result_in;
        rsp0_valid_d = !grant_q;
        rsp1_valid_d = grant_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign rsp0_valid_out = rsp0_valid_q;
  assign rsp1_valid_out = rsp1_valid_q;
  assign rsp_data_out   = rsp_data_q;
  assign alu_a_out      = alu_a_q;
  assign alu_b_out      = alu_b_q;
  assign alu_s0_out     = alu_op_q[0];
  assign alu_s1_out     = alu_op_q[1];
  assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with random and directed traffic
module tb_alu_share_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       req0_valid_in, req1_valid_in;
  logic [1:0] req0_op_in, req1_op_in;
  logic [3:0] req0_a_in, req0_b_in, req1_a_in, req1_b_in;
  logic       req0_ready_out, req1_ready_out;
  logic       rsp0_valid_out, rsp1_valid_out;
  logic       rsp0_ready_in, rsp1_ready_in;
  logic [3:0] rsp_data_out, alu_a_out, alu_b_out, alu_result_in;
  logic       alu_s0_out, alu_s1_out, busy_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         id;
    logic [3:0] data;
  } exp_t;
  exp_t sb[$];

  bit         m_occ, m_gnt, m_last;
  int         m_age;
  logic [1:0] m_op;
  logic [3:0] m_a, m_b, m_data;
  bit         acc0, acc1;
  int         gseq[$];

  always #5 clk_in = ~clk_in;

  alu_share_arbiter #(.DATA_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req0_valid_in(req0_valid_in), .req0_op_in(req0_op_in), .req0_a_in(req0_a_in),
    .req0_b_in(req0_b_in), .req0_ready_out(req0_ready_out),
    .req1_valid_in(req1_valid_in), .req1_op_in(req1_op_in), .req1_a_in(req1_a_in),
    .req1_b_in(req1_b_in), .req1_ready_out(req1_ready_out),
    .rsp0_valid_out(rsp0_valid_out), .rsp0_ready_in(rsp0_ready_in),
    .rsp1_valid_out(rsp1_valid_out), .rsp1_ready_in(rsp1_ready_in),
    .rsp_data_out(rsp_data_out), .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
    .alu_s0_out(alu_s0_out), .alu_s1_out(alu_s1_out), .alu_result_in(alu_result_in),
    .busy_out(busy_out)
  );

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      2'd0:    r = 15 - int'(a);
      2'd1:    r = (int'(a) + int'(b)) % 16;
      2'd2:    r = (int'(a) - int'(b) + 16) % 16;
      default: r = (2 * int'(a)) % 16;
    endcase
    return 4'(r);
  endfunction

  // External ALU
  always_comb alu_result_in = alu_ref({alu_s1_out, alu_s0_out}, alu_a_out, alu_b_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_gnt = 0; m_last = 1; m_age = 0;
    m_op = 0; m_a = 0; m_b = 0; m_data = 0;
    acc0 = 0; acc1 = 0;
    sb.delete();
  endtask

  task automatic set_in(input bit v0, input int op0, input int a0, input int b0,
                        input bit v1, input int op1, input int a1, input int b1,
                        input bit r0, input bit r1);
    req0_valid_in = v0; req0_op_in = 2'(op0); req0_a_in = 4'(a0); req0_b_in = 4'(b0);
    req1_valid_in = v1; req1_op_in = 2'(op1); req1_a_in = 4'(a1); req1_b_in = 4'(b1);
    rsp0_ready_in = r0; rsp1_ready_in = r1;
  endtask

  task automatic check_regs();
    chk("busy", busy_out, m_occ);
    chk("rsp0_valid", rsp0_valid_out, m_occ && m_age >= 1 && !m_gnt);
    chk("rsp1_valid", rsp1_valid_out, m_occ && m_age >= 1 && m_gnt);
    chk("rsp_data_reg", rsp_data_out, m_data);
    chk("alu_a", alu_a_out, m_a);
    chk("alu_b", alu_b_out, m_b);
    chk("alu_sel", {alu_s1_out, alu_s0_out}, m_op);
  endtask

  // One clock: check ready just after inputs settle, advance the model at the edge, check registers after
  task automatic step();
    bit w;
    #1;
    acc0 = 0; acc1 = 0;
    if (!m_occ && rst_n_in) begin
      if (req0_valid_in && req1_valid_in) w = FIXED ? 1'b0 : !m_last;
      else w = req1_valid_in;
      acc0 = req0_valid_in && !w;
      acc1 = req1_valid_in && w;
    end
    chk("req0_ready", req0_ready_out, acc0);
    chk("req1_ready", req1_ready_out, acc1);
    @(posedge clk_in);
    if (m_occ) begin
      if (m_age == 0) begin
        m_age  = 1;
        m_data = alu_ref(m_op, m_a, m_b);
      end else if (m_gnt ? rsp1_ready_in : rsp0_ready_in) begin
        m_occ = 0;
      end
    end else if (acc0 || acc1) begin
      m_occ = 1; m_age = 0; m_gnt = acc1; m_last = acc1;
      m_op  = acc1 ? req1_op_in : req0_op_in;
      m_a   = acc1 ? req1_a_in : req0_a_in;
      m_b   = acc1 ? req1_b_in : req0_b_in;
      sb.push_back('{id: acc1 ? 1 : 0, data: alu_ref(m_op, m_a, m_b)});
    end
    @(negedge clk_in);
    check_regs();
  endtask

  task automatic pop_check(input int id);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected_rsp actual=rsp%0d data=%0h expected=none t=%0t", id, rsp_data_out, $time);
    end else begin
      e = sb.pop_front();
      chk("sb_rsp_id", id, e.id);
      chk("sb_rsp_data", rsp_data_out, e.data);
    end
  endtask

  // Monitor: a response handshake will complete at the coming edge
  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_n_in && rsp0_valid_out && rsp0_ready_in) pop_check(0);
      if (rst_n_in && rsp1_valid_out && rsp1_ready_in) pop_check(1);
    end
  end

  task automatic single(input bit id, input int op, input int a, input int b, input int exp);
    if (id) set_in(0, 0, 0, 0, 1, op, a, b, 1, 1);
    else    set_in(1, op, a, b, 0, 0, 0, 0, 1, 1);
    step();
    req0_valid_in = 0; req1_valid_in = 0;
    step();
    chk("directed_data", rsp_data_out, exp);
    step();
  endtask

  task automatic mid_reset();
    #2 rst_n_in = 0;
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_rsp0_valid", rsp0_valid_out, 0);
    chk("rst_rsp1_valid", rsp1_valid_out, 0);
    chk("rst_rsp_data", rsp_data_out, 0);
    chk("rst_alu", {alu_a_out, alu_b_out, alu_s1_out, alu_s0_out}, 0);
    chk("rst_ready", {req0_ready_out, req1_ready_out}, 0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1;
  endtask

  initial begin
    rst_n_in = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk_in);
    check_regs();
    rst_n_in = 1;

    // Single req0 add 3+5
    set_in(1, 1, 3, 5, 0, 0, 0, 0, 1, 0);
    step();
    req0_valid_in = 0;
    step();
    chk("t1_data", rsp_data_out, 8);
    step();

    // req1 subtracts
    single(1, 2, 13, 2, 11);
    single(1, 2, 6, 4, 2);

    // Both valid continuously
    gseq.delete();
    set_in(1, 0, 2, 0, 1, 3, 7, 0, 1, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp0_valid_out) begin gseq.push_back(0); chk("t3_data0", rsp_data_out, 13); end
      if (rsp1_valid_out) begin gseq.push_back(1); chk("t3_data1", rsp_data_out, 14); end
    end
    chk("t3_grant_count", gseq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      chk("t3_grant_order", gseq[i], FIXED ? 0 : i % 2);

    // Drain any op left in flight
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step();

    // Backpressure on requester 0 while requester 1 waits
    set_in(1, 1, 2, 10, 1, 1, 1, 1, 0, 1);
    step();
    req0_valid_in = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_data", rsp_data_out, 12);
      chk("t4_hold_valid", rsp0_valid_out, 1);
    end
    rsp0_ready_in = 1;
    step();
    step();
    req1_valid_in = 0;
    repeat (3) step();

    // Wrap cases
    single(0, 1, 15, 15, 14);
    single(0, 2, 0, 1, 15);
    single(0, 3, 15, 0, 14);

    // Reset during EXEC
    set_in(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step();
    mid_reset();
    single(0, 1, 4, 4, 8);

    // Reset during RESP
    set_in(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    step();
    req0_valid_in = 0;
    step();
    mid_reset();
    single(0, 0, 5, 0, 10);

    // Random traffic
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid_in || acc0 || $urandom_range(7) == 0) begin
        req0_valid_in = 1'($urandom_range(1));
        req0_op_in = 2'($urandom); req0_a_in = 4'($urandom); req0_b_in = 4'($urandom);
      end
      if (!req1_valid_in || acc1 || $urandom_range(7) == 0) begin
        req1_valid_in = 1'($urandom_range(1));
        req1_op_in = 2'($urandom); req1_a_in = 4'($urandom); req1_b_in = 4'($urandom);
      end
      rsp0_ready_in = ($urandom_range(2) != 0);
      rsp1_ready_in = ($urandom_range(2) != 0);
      step();
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (4) step();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 4-bit ALU (ops: invert A, A+B, A-B, double A; select S1:S0) between two requesters.
- Arbitrates round-robin, drives the ALU operand and select inputs, registers the result, and returns it over a per-requester valid/ready response.
- Sits between two client controllers and the single ALU instance; the ALU itself is external.

Parameters:
- DATA_W, 4, operand/result width; all arithmetic is modulo 2^DATA_W.

Ports:
- clk_in  input  1  system clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- req0_valid_in  input  1  requester 0 has an op
- req0_op_in  input  2  requester 0 select {S1,S0}
- req0_a_in  input  DATA_W  requester 0 operand A
- req0_b_in  input  DATA_W  requester 0 operand B
- req0_ready_out  output  1  requester 0 request accepted this cycle
- req1_valid_in / req1_op_in / req1_a_in / req1_b_in / req1_ready_out  same as requester 0
- rsp0_valid_out  output  1  result for requester 0 available
- rsp0_ready_in  input  1  requester 0 consumes result
- rsp1_valid_out  output  1  result for requester 1 available
- rsp1_ready_in  input  1  requester 1 consumes result
- rsp_data_out  output  DATA_W  registered result, shared by both response channels
- alu_a_out  output  DATA_W  to ALU A_in
- alu_b_out  output  DATA_W  to ALU B_in
- alu_s0_out  output  1  to ALU S0_in
- alu_s1_out  output  1  to ALU S1_in
- alu_result_in  input  DATA_W  from ALU output
- busy_out  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset values: state = IDLE, all ready/valid = 0, rsp_data_out = 0, alu_* = 0, last_grant = 1, busy_out = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational; only the arbitration winner sees ready = 1. The loser sees 0.
  - Single valid request: it wins.
  - Both requests valid: the requester != last_grant wins.
  - On the accept edge:
    - Latch op/A/B into the alu_* registers.
    - Record grant; set last_grant = winner.
    - Go to EXEC.
- EXEC: alu_* held stable for one full cycle. At the next edge:
  - rsp_data_out <= alu_result_in.
  - rspN_valid_out <= 1 for the granted requester only.
  - Go to RESP.
- RESP:
  - rspN_valid_out held high and rsp_data_out held stable until rspN_ready_in = 1.
  - On that edge, valid drops and the FSM returns to IDLE.
  - No new request is accepted in EXEC or RESP.
- Latency and throughput:
  - Accept at edge k; rsp valid visible after edge k+1.
  - With rsp_ready tied high, a new accept is possible at edge k+3, giving 1 op per 3 cycles.
- alu_* outputs retain the last op's values in IDLE; they are not cleared.
- Result is whatever the ALU returns. Expected ALU values for verification, all mod 16:
  - op 00: ~A
  - op 01: A+B
  - op 10: A-B
  - op 11: A<<1
- Boundary conditions:
  - Requester drops valid before ready: no accept, no state change.
  - rsp_ready asserted while rsp_valid = 0: ignored.
  - rsp_ready of the non-granted requester: ignored.
  - Simultaneous new request during RESP: waits; it is arbitrated in the IDLE cycle after the response completes.
  - Reset mid-operation: immediate return to IDLE, in-flight op discarded, all valids drop asynchronously, last_grant returns to 1.
  - Starvation-free: with both requesters permanently valid, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; last_grant is still tracked but ignored for arbitration.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset then single req0 op=01, A=3, B=5, rsp0_ready=1 -> req0_ready high at the accept edge; alu_a/b/s = 3/5/01 during EXEC; rsp0_valid with rsp_data_out=8 one edge later; busy_out high for 2 cycles.
- req1 op=10, A=13, B=2 then A=6, B=4 -> rsp_data_out=11 then 2; rsp0_valid never asserts.
- Both requesters continuously valid, req0 op=00 A=2 and req1 op=11 A=7 -> grant order 0,1,0,1; results alternate 13,14; with ARB_FIXED_PRIO_EN, all grants to 0.
- Backpressure: req0 op=01 A=2 B=10, rsp0_ready low 5 cycles -> rsp0_valid and rsp_data_out=12 held stable; req1 valid meanwhile gets no ready until one cycle after rsp0 handshake.
- Wrap: op=01 A=15 B=15 -> 14; op=10 A=0 B=1 -> 15; op=11 A=15 -> 14.
- Assert rst_n_in low during EXEC and during RESP -> all outputs zero immediately; after release, a single req0 is accepted in the first IDLE cycle.
